// File: rtl/zero_pattern_gen_pkg.sv
// Shared constants and state encoding for the zero-count pattern generator.
package zero_pattern_gen_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ZCNT_W    = 4;
  localparam int unsigned TOTAL_W   = 7;
  localparam int unsigned MAX_ZEROS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/zero_pattern_gen_zero_counter8.sv
// Combinational count of zero bits in an 8-bit word.
module zero_counter8
  import zero_pattern_gen_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [ZCNT_W-1:0] zeros_c
);

  always_comb begin
    zeros_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      zeros_c = zeros_c + ZCNT_W'(!value[i]);
    end
  end

endmodule

// File: rtl/zero_pattern_gen.sv
// Enumerates, in ascending order, every byte whose zero count equals req_zeros,
// streaming them over a valid/ready handshake.
module zero_pattern_gen
  import zero_pattern_gen_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ZCNT_W-1:0]  req_zeros,
  output logic [DW-1:0]      data,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [TOTAL_W-1:0] total,
  output logic               err
);

  state_t              state;
  logic [DATA_W-1:0]   cand;
  logic [ZCNT_W-1:0]   req;
  logic [ZCNT_W-1:0]   cand_zeros_c;

  zero_counter8 u_zero_counter8 (
    .value   (cand),
    .zeros_c (cand_zeros_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      req   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      total <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // Transfers are counted in every state; IDLE never holds valid high.
      if (valid && ready) begin
        total <= total + TOTAL_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (req_zeros > ZCNT_W'(MAX_ZEROS)) begin
              err <= 1'b1;
            end else begin
              req   <= req_zeros;
              cand  <= '0;
              total <= '0;
              busy  <= 1'b1;
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          // Evaluate a new candidate only when the output slot is free.
          if (!valid || ready) begin
            if (cand_zeros_c == req) begin
              data  <= DW'(cand);
              valid <= 1'b1;
            end else begin
              valid <= 1'b0;
            end
            if (cand == DATA_W'(255)) begin
              state <= DRAIN;
            end else begin
              cand <= cand + DATA_W'(1);
            end
          end
        end

        DRAIN: begin
          if (!valid) begin
            state <= FIN;
          end else if (ready) begin
            valid <= 1'b0;
            state <= FIN;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
